riscv_mem_wb_stage: RTL and testbench
=====================================

// Module: riscv_mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register, write-back mux and 32x64 integer register file for the RV64 core.
//  Sits directly downstream of the LD/SD memory stage: consumes its registered load data and
//  address_error flag plus the forwarded ALU result, and commits one result per cycle to rd.
//  Provides combinational rs1/rs2 reads for decode and a retire counter for bring-up.
// PARAMETERS
//  XLEN      64  datapath width
//  NREGS     32  architectural registers (x0 hardwired zero)
//  CNT_W     32  retire counter width
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  in_valid       in   1     MEM stage holds a real instruction this cycle
//  in_rd_addr     in   5     destination register index
//  in_regwrite    in   1     instruction writes rd
//  in_mem2reg     in   1     1 = write load data, 0 = write ALU result
//  in_alures      in   XLEN  ALU result from execute
//  mem_rdata      in   XLEN  load data from memory stage (valid 1 cycle after capture)
//  mem_addr_err   in   1     memory stage address_error (valid with mem_rdata)
//  stall          in   1     hold WB register contents
//  flush          in   1     kill incoming instruction
//  rs1_addr       in   5     read port 1 index
//  rs2_addr       in   5     read port 2 index
//  rs1_data       out  XLEN  read port 1 data
//  rs2_data       out  XLEN  read port 2 data
//  wb_we          out  1     register file write strobe this cycle
//  wb_rd_addr     out  5     destination being written (forwarding)
//  wb_data        out  XLEN  value being written (forwarding)
//  exc_flag       out  1     sticky: a load/store hit address_error
//  retire_cnt     out  CNT_W instructions committed (wraps)
// BEHAVIOUR
//  - Reset (rst_n=0, async): WB register valid=0, all fields 0, all registers 0, held-load 0,
//    exc_flag=0, retire_cnt=0; wb_we=0, wb_data=0 while reset asserted.
//  - Capture: at posedge, if flush -> valid<=0; else if !stall -> register <= in_*; else hold.
//    flush has priority over stall.
//  - Load data: mem_rdata/mem_addr_err are sampled on the first cycle after capture (FIRST)
//    into a held register; while stalled (HELD) the held copy is used, never the live port.
//    States: IDLE (valid=0) -> FIRST on capture -> HELD if stall, -> FIRST/IDLE on next capture.
//  - wb_data = mem2reg ? (FIRST ? mem_rdata : held) : alures.
//  - wb_we = valid & regwrite & (rd!=0) & !err & !stall; write happens at that posedge.
//    err = mem2reg ? addr_err(FIRST live / HELD copy) : 0.
//  - Instruction in WB with stall=0 completes even if flush is asserted (flush kills only
//    the incoming one). A stalled instruction commits exactly once, on its non-stall cycle.
//  - err on a mem2reg instruction: no write, exc_flag<=1 (sticky until reset), still retires.
//  - retire_cnt increments by 1 per valid non-stalled WB cycle; wraps 2^CNT_W-1 -> 0.
//  - Reads: rsN_data = (addr==0) ? 0 : regs[addr]; combinational, no latency.
//  - Writes to x0 are dropped; wb_we stays 0.
// CONFIGURATION
//  WB_BYPASS_EN defined: if wb_we and rsN_addr==wb_rd_addr (!=0), rsN_data = wb_data
//    (write-through, same-cycle read sees new value).
//  Undefined: rsN_data returns the pre-write value; new value visible the next cycle.
// STRUCTURE
//  Package riscv_core_pkg: XLEN, REG_ADDR_W=5, NREGS, opcode constants (LOAD=7'b0000011,
//    STORE=7'b0100011), funct3 LD/SD=3'b011, WB state enum {IDLE,FIRST,HELD}.
//  Sub-module riscv_regfile: 2 async read ports, 1 sync write port, x0 zero, bypass macro.
// TESTING
//  1 Reset mid-op: assert rst_n=0 with valid instr in WB -> wb_we=0, x5 reads 0, retire_cnt=0.
//  2 ALU write: in_alures=64'h1234, rd=5, mem2reg=0 -> next cycle wb_we=1, x5=64'h1234 after.
//  3 Load+stall: mem2reg=1, rd=7, mem_rdata=64'hDEAD then changes to 0 during 3 stall
//    cycles -> x7=64'hDEAD written once, retire_cnt +1.
//  4 Error: mem2reg=1, mem_addr_err=1 -> no write to rd, exc_flag=1 stays set after.
//  5 x0 + flush: rd=0 write -> x0 reads 0; flush&stall together -> next WB valid=0.
//  6 Bypass: write x3=64'hA5 while rs1_addr=3 -> rs1_data=64'hA5 (WB_BYPASS_EN) / old (off).

Source files
------------

// File: rtl/riscv_core_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_pkg
// Shared widths, opcode constants, the write-back state enum and the MEM/WB
// pipeline payload used by the RV64 core back end.
// -----------------------------------------------------------------------------
package riscv_core_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned CNT_W      = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_LD     = 3'b011;
    localparam logic [2:0] F3_SD     = 3'b011;

    // IDLE: no instruction; FIRST: cycle after capture (live load data);
    // HELD: stalled past FIRST, load data comes from the held copy.
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_FIRST = 2'd1,
        WB_HELD  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  mem2reg;
        logic [XLEN-1:0]       alures;
    } wb_payload_t;

endpackage

// File: rtl/riscv_regfile.sv
// -----------------------------------------------------------------------------
// riscv_regfile
// 32 x XLEN integer register file, x0 hardwired to zero.
// Ports: clk, rst_n (async active-low), i_we/i_waddr/i_wdata (sync write),
//        i_raddr1/i_raddr2 -> o_rdata1/o_rdata2 (combinational reads).
// Macro WB_BYPASS_EN: a read of the register being written this cycle
//        returns the new value (write-through); otherwise the old value.
// -----------------------------------------------------------------------------
module riscv_regfile
    import riscv_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [XLEN-1:0]       o_rdata1,
    output logic [XLEN-1:0]       o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != '0);

    // Storage; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports
    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef WB_BYPASS_EN
        if (w_wr_ok && (i_raddr1 == i_waddr)) o_rdata1 = i_wdata;
        if (w_wr_ok && (i_raddr2 == i_waddr)) o_rdata2 = i_wdata;
`endif
    end

endmodule

// File: rtl/riscv_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// riscv_mem_wb_stage
// MEM/WB pipeline register, write-back mux, register file and retire counter.
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   in_valid, in_rd_addr, in_regwrite,
//   in_mem2reg, in_alures             instruction from the MEM stage
//   mem_rdata, mem_addr_err           load data / address error (cycle after capture)
//   stall, flush                      hold WB / kill incoming (flush wins)
//   rs1_addr, rs2_addr -> rs1_data, rs2_data   decode read ports
//   wb_we, wb_rd_addr, wb_data        current write (forwarding)
//   exc_flag                          sticky address-error indication
//   retire_cnt                        committed instruction count (wraps)
// Macro WB_BYPASS_EN: same-cycle write-through on the read ports.
// -----------------------------------------------------------------------------
module riscv_mem_wb_stage
    import riscv_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_regwrite,
    input  logic                  in_mem2reg,
    input  logic [XLEN-1:0]       in_alures,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_addr_err,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic                  exc_flag,
    output logic [CNT_W-1:0]      retire_cnt
);

    wb_state_e        r_state;
    wb_payload_t      r_wb;
    logic             r_valid;
    logic [XLEN-1:0]  r_held_data;
    logic             r_held_err;
    logic             r_exc;
    logic [CNT_W-1:0] r_retire;

    wb_payload_t      w_in;
    logic             w_first;
    logic             w_err;
    logic             w_commit;
    logic             w_we;
    logic [XLEN-1:0]  w_data;

    // Write-back selection: live load data only in FIRST, held copy afterwards
    always_comb begin
        w_in          = '0;
        w_in.rd       = in_rd_addr;
        w_in.regwrite = in_regwrite;
        w_in.mem2reg  = in_mem2reg;
        w_in.alures   = in_alures;
        w_first       = (r_state == WB_FIRST);
        w_err         = r_wb.mem2reg & (w_first ? mem_addr_err : r_held_err);
        w_commit      = r_valid & ~stall;
        w_we          = w_commit & r_wb.regwrite & (r_wb.rd != '0) & ~w_err;
        w_data        = r_wb.mem2reg ? (w_first ? mem_rdata : r_held_data) : r_wb.alures;
    end

    // Pipeline register, load-data capture state, exception and retire tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WB_IDLE;
            r_wb        <= '0;
            r_valid     <= 1'b0;
            r_held_data <= '0;
            r_held_err  <= 1'b0;
            r_exc       <= 1'b0;
            r_retire    <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
                r_state <= WB_IDLE;
            end else if (!stall) begin
                r_valid <= in_valid;
                r_wb    <= w_in;
                r_state <= in_valid ? WB_FIRST : WB_IDLE;
            end else if (r_state == WB_FIRST) begin
                r_state <= WB_HELD;
            end

            // Memory-stage outputs are only meaningful in the first cycle
            if (w_first) begin
                r_held_data <= mem_rdata;
                r_held_err  <= mem_addr_err;
            end

            if (w_commit && w_err) r_exc <= 1'b1;
            if (w_commit)          r_retire <= r_retire + CNT_W'(1);
        end
    end

    riscv_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (r_wb.rd),
        .i_wdata  (w_data),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (rs1_data),
        .o_rdata2 (rs2_data)
    );

    assign wb_we      = w_we;
    assign wb_rd_addr = r_wb.rd;
    assign wb_data    = w_data;
    assign exc_flag   = r_exc;
    assign retire_cnt = r_retire;

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_riscv_mem_wb_stage
// Directed bench: stimulus pushes expected register writes into a queue, a
// negedge monitor pops one entry per observed write strobe and compares.
// -----------------------------------------------------------------------------
module tb_riscv_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_rd_addr;
    logic        in_regwrite;
    logic        in_mem2reg;
    logic [63:0] in_alures;
    logic [63:0] mem_rdata;
    logic        mem_addr_err;
    logic        stall;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        exc_flag;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    riscv_mem_wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_rd_addr   (in_rd_addr),
        .in_regwrite  (in_regwrite),
        .in_mem2reg   (in_mem2reg),
        .in_alures    (in_alures),
        .mem_rdata    (mem_rdata),
        .mem_addr_err (mem_addr_err),
        .stall        (stall),
        .flush        (flush),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_we        (wb_we),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .exc_flag     (exc_flag),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic m2r, input logic [63:0] alu);
        in_valid    = 1'b1;
        in_rd_addr  = rd;
        in_regwrite = 1'b1;
        in_mem2reg  = m2r;
        in_alures   = alu;
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        exp_wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", wb_rd_addr, wb_data);
            end else begin
                exp_wr_t e;
                e = exp_q.pop_front();
                if (wb_rd_addr === e.rd && wb_data === e.data) n_pass++;
                else $display("FAIL wb_write: got rd=%0d data=%h expected rd=%0d data=%h",
                              wb_rd_addr, wb_data, e.rd, e.data);
            end
        end
    end

    initial begin
        logic [63:0] exp_byp;
        rst_n = 1'b0; in_valid = 1'b0; in_rd_addr = '0; in_regwrite = 1'b0;
        in_mem2reg = 1'b0; in_alures = '0; mem_rdata = '0; mem_addr_err = 1'b0;
        stall = 1'b0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
        step(); step();
        rs1_addr = 5'd5;
        #1;
        chk("reset_wb_we", 64'(wb_we), 64'd0);
        chk("reset_retire", 64'(retire_cnt), 64'd0);
        chk("reset_exc", 64'(exc_flag), 64'd0);
        chk("reset_x5", rs1_data, 64'd0);
        rst_n = 1'b1;

        // ALU write to x5
        step();
        issue(5'd5, 1'b0, 64'h1234);
        push(5'd5, 64'h1234);
        step();
        in_valid = 1'b0;
        step();
        rs1_addr = 5'd5;
        #1;
        chk("alu_x5", rs1_data, 64'h1234);
        chk("alu_retire", 64'(retire_cnt), 64'd1);

        // Same-cycle read of the register being written
        issue(5'd3, 1'b0, 64'hA5);
        push(5'd3, 64'hA5);
        step();
        in_valid = 1'b0;
        rs1_addr = 5'd3;
        rs2_addr = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        exp_byp = 64'hA5;
`else
        exp_byp = 64'h0;
`endif
        chk("bypass_rs1", rs1_data, exp_byp);
        chk("bypass_rs2_other", rs2_data, 64'h1234);
        step();
        chk("x3_after", rs1_data, 64'hA5);
        chk("bypass_retire", 64'(retire_cnt), 64'd2);

        // Load to x7, stalled 3 cycles while the live port changes
        issue(5'd7, 1'b1, 64'h0);
        step();
        in_valid  = 1'b0;
        mem_rdata = 64'hDEAD;
        stall     = 1'b1;
        step();
        mem_rdata = 64'h0;
        step();
        step();
        chk("stall_no_we", 64'(wb_we), 64'd0);
        push(5'd7, 64'hDEAD);
        stall = 1'b0;
        step();
        rs1_addr = 5'd7;
        #1;
        chk("load_x7", rs1_data, 64'hDEAD);
        chk("load_retire", 64'(retire_cnt), 64'd3);

        // Load with address error to x9
        issue(5'd9, 1'b1, 64'h0);
        step();
        in_valid     = 1'b0;
        mem_addr_err = 1'b1;
        mem_rdata    = 64'hBEEF;
        step();
        mem_addr_err = 1'b0;
        mem_rdata    = 64'h0;
        rs1_addr     = 5'd9;
        #1;
        chk("err_exc", 64'(exc_flag), 64'd1);
        chk("err_x9", rs1_data, 64'd0);
        chk("err_retire", 64'(retire_cnt), 64'd4);
        step(); step();
        chk("err_exc_sticky", 64'(exc_flag), 64'd1);

        // Write to x0 is dropped
        issue(5'd0, 1'b0, 64'hFFFF);
        step();
        in_valid = 1'b0;
        chk("x0_no_we", 64'(wb_we), 64'd0);
        step();
        rs1_addr = 5'd0;
        #1;
        chk("x0_read", rs1_data, 64'd0);
        chk("x0_retire", 64'(retire_cnt), 64'd5);

        // flush with stall kills the incoming instruction
        issue(5'd10, 1'b0, 64'h77);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        chk("flush_stall_no_we", 64'(wb_we), 64'd0);
        step();
        rs1_addr = 5'd10;
        #1;
        chk("flush_stall_x10", rs1_data, 64'd0);
        chk("flush_stall_retire", 64'(retire_cnt), 64'd5);

        // flush does not kill the instruction already in WB
        issue(5'd12, 1'b0, 64'hC);
        push(5'd12, 64'hC);
        step();
        issue(5'd13, 1'b0, 64'hD);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        rs1_addr = 5'd12;
        rs2_addr = 5'd13;
        #1;
        chk("flush_x12", rs1_data, 64'hC);
        chk("flush_x13", rs2_data, 64'd0);
        chk("flush_retire", 64'(retire_cnt), 64'd6);

        // Reset with a valid instruction in WB
        issue(5'd5, 1'b0, 64'h999);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        rs1_addr = 5'd5;
        #1;
        chk("midrst_wb_we", 64'(wb_we), 64'd0);
        chk("midrst_wb_data", wb_data, 64'd0);
        chk("midrst_retire", 64'(retire_cnt), 64'd0);
        chk("midrst_exc", 64'(exc_flag), 64'd0);
        chk("midrst_x5", rs1_data, 64'd0);
        step();
        rst_n = 1'b1;
        step(); step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
